axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI3 slave (responder) backed by an internal word-addressed SRAM array.
//  It is the far end of the CPU-side AXI bridge: it answers arid/awid-tagged single-beat and INCR burst
//  transactions. Standalone bring-up memory for the mycpu env, and the memory model in the bridge test bench.
//  Read and write channels are independent; one outstanding read and one outstanding write at a time.
// PARAMETERS
//  MEM_AW  12  word-address width; array holds 2**MEM_AW 32-bit words (byte range 0..4*2**MEM_AW-1)
//  ID_W    4   width of arid/rid/awid/wid/bid
// PORTS
//  clk      in   1     clock, all logic on posedge
//  aresetn  in   1     synchronous active-low reset
//  arid     in   ID_W  read ID, echoed on rid
//  araddr   in   32    read byte address
//  arlen    in   8     beats-1; legal 0..15
//  arsize   in   3     bytes/beat = 1<<arsize; legal 0..2
//  arburst  in   2     01 INCR, 00 FIXED; 10/11 -> error
//  arlock/arcache/arprot  in  2/4/3  ignored
//  arvalid  in   1     read address valid
//  arready  out  1     read address accepted
//  rid      out  ID_W  latched arid
//  rdata    out  32    full word; master selects byte lanes
//  rresp    out  2     00 OKAY, 10 SLVERR
//  rlast    out  1     final beat
//  rvalid   out  1     read data valid
//  rready   in   1     master accepts beat
//  awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  as read side
//  awlock/awcache/awprot  in  2/4/3  ignored
//  awvalid  in   1 ; awready out 1     write address handshake
//  wid      in   ID_W  ignored (AXI3 field)
//  wdata    in   32 ; wstrb in 4       byte lane i written when wstrb[i]
//  wlast    in   1 ; wvalid in 1 ; wready out 1
//  bid      out  ID_W ; bresp out 2 ; bvalid out 1 ; bready in 1
// BEHAVIOUR
//  Reset: every output 0; FSMs to IDLE; SRAM contents NOT cleared.
//  arready/awready rise the first cycle after aresetn=1.
//  Reset mid-burst: transaction dropped, no bresp issued, partial writes remain in SRAM.
//  Read FSM R_IDLE -> R_DATA:
//   - R_IDLE: arready=1. On arvalid&arready latch id, addr, len, size, burst; beat_cnt=0.
//   - Cycle after acceptance: rvalid=1, rdata=mem[addr[MEM_AW+1:2]], rlast=(len==0); arready=0.
//   - On rvalid&rready: addr+=1<<size (INCR), unchanged (FIXED); beat_cnt++.
//     Next beat is valid the following cycle, so back-to-back beats are possible.
//     rdata/rresp/rlast held stable while rvalid&~rready.
//   - Last beat accepted (beat_cnt==len): rvalid=0, R_IDLE; arready=1 the next cycle.
//   - Error: address beyond array, arlen>15, arsize>2, or arburst not in {00,01}:
//     every beat rresp=10, rdata=0; beat count still honoured.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: awready=1, wready=0. W beats arriving first wait; AW+W presented together is legal.
//   - W_DATA: wready=1. On wvalid&wready write the wstrb-enabled lanes of mem[addr] in the same edge;
//     advance addr as on the read side.
//   - Burst end = wlast or beat_cnt==len, whichever first; then W_RESP.
//     bvalid=1, bid=awid, bresp=00; 10 if wlast/count disagree or any error condition.
//     Error beats are not written.
//   - W_RESP: bvalid held until bready; then W_IDLE, awready=1 next cycle.
//  Simultaneous read fetch and write to the same word in one cycle: read returns the OLD word;
//  the write is visible to any later beat.
//  No address-channel acceptance while its FSM is busy: max one outstanding transaction per direction.
// TESTING
//  1. Reset, then AW(0x10,len0,size2)+W(0xDEADBEEF,strb F) same cycle, bready=1
//     -> bvalid 2 cycles after AW, bresp=00; AR(0x10,id1) -> rdata=DEADBEEF, rid=1, rlast=1.
//  2. Write strb 0011 data 0x12345678 over 0xFFFFFFFF, then read -> rdata=0xFFFF5678.
//  3. INCR read len=3 from 0x0 with rready toggling 1,0,1,... -> 4 beats in address order, rlast on 4th only,
//     outputs stable during stalls.
//  4. Read and write of word 0x20 in the same cycle (old=0, new=0xA5) -> read returns 0;
//     following read returns 0xA5.
//  5. AR to 0x4000 (MEM_AW=12, out of range) -> rresp=10, rdata=0; arburst=10 -> rresp=10.
//     Write burst len=2 with wlast on beat 1 -> bresp=10.
//  6. Deassert aresetn during beat 2 of a len=3 read -> rvalid=0 next cycle, arready=1 one cycle after release,
//     SRAM contents intact.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the axi_sram_slave responder.
// The master modport drives requests and write data; the slave modport drives responses.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM: independent read and write FSMs,
// one outstanding transaction per direction, INCR/FIXED bursts up to 16 beats.
module axi_sram_slave #(
    parameter int MEM_AW = 12,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    axi_sram_slave_if.slave bus
);
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [1 << MEM_AW];
    logic        live;

    function automatic logic out_of_range(input logic [31:0] a);
        return a[31:MEM_AW+2] != '0;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b01) ? a + (32'd1 << size) : a;
    endfunction

    function automatic logic bad_txn(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        return (len > 8'd15) || (size > 3'd2) || burst[1];
    endfunction

    // Held low through reset so the address channels only open the cycle after release.
    always_ff @(posedge clk) begin
        if (!aresetn) live <= 1'b0;
        else          live <= 1'b1;
    end

    // ---------------- read side ----------------
    r_state_t        r_state, r_next;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr, r_addr_nxt, rdata_q;
    logic [7:0]      r_len, r_cnt;
    logic [2:0]      r_size;
    logic [1:0]      r_burst, rresp_q;
    logic            r_bad, rlast_q, ar_fire, r_fire, ar_err;

    assign ar_fire    = bus.arvalid & bus.arready;
    assign r_fire     = bus.rvalid & bus.rready;
    assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);
    assign ar_err     = bad_txn(bus.arlen, bus.arsize, bus.arburst) | out_of_range(bus.araddr);

    always_ff @(posedge clk) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.arready = live;
                if (live && bus.arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready && rlast_q) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is fetched on the edge that accepts the address or the previous beat,
    // so a same-edge write to that word is not yet visible.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            rlast_q <= 1'b0;
        end else if (ar_fire) begin
            r_id    <= bus.arid;
            r_addr  <= bus.araddr;
            r_len   <= bus.arlen;
            r_cnt   <= '0;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_bad   <= bad_txn(bus.arlen, bus.arsize, bus.arburst);
            rlast_q <= (bus.arlen == 8'd0);
            rdata_q <= ar_err ? 32'h0 : mem[bus.araddr[MEM_AW+1:2]];
            rresp_q <= ar_err ? 2'b10 : 2'b00;
        end else if (r_fire && !rlast_q) begin
            r_addr  <= r_addr_nxt;
            r_cnt   <= r_cnt + 8'd1;
            rlast_q <= (r_cnt + 8'd1 == r_len);
            rdata_q <= (r_bad || out_of_range(r_addr_nxt)) ? 32'h0 : mem[r_addr_nxt[MEM_AW+1:2]];
            rresp_q <= (r_bad || out_of_range(r_addr_nxt)) ? 2'b10 : 2'b00;
        end
    end

    assign bus.rid   = r_id;
    assign bus.rdata = rdata_q;
    assign bus.rresp = rresp_q;
    assign bus.rlast = rlast_q;

    // ---------------- write side ----------------
    w_state_t        w_state, w_next;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_addr;
    logic [7:0]      w_len, w_cnt;
    logic [2:0]      w_size;
    logic [1:0]      w_burst, bresp_q;
    logic            w_bad, w_sticky, aw_fire, w_fire, w_beat_err, w_last_beat;

    assign aw_fire     = bus.awvalid & bus.awready;
    assign w_fire      = bus.wvalid & bus.wready;
    assign w_beat_err  = w_bad | out_of_range(w_addr);
    assign w_last_beat = bus.wlast | (w_cnt == w_len);

    always_ff @(posedge clk) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = live;
                if (live && bus.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // The burst closes on wlast or the beat count, whichever comes first; disagreement is an error.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_bad    <= 1'b0;
            w_sticky <= 1'b0;
            bresp_q  <= 2'b00;
        end else if (aw_fire) begin
            w_id     <= bus.awid;
            w_addr   <= bus.awaddr;
            w_len    <= bus.awlen;
            w_cnt    <= '0;
            w_size   <= bus.awsize;
            w_burst  <= bus.awburst;
            w_bad    <= bad_txn(bus.awlen, bus.awsize, bus.awburst);
            w_sticky <= 1'b0;
        end else if (w_fire) begin
            w_addr   <= next_addr(w_addr, w_size, w_burst);
            w_cnt    <= w_cnt + 8'd1;
            w_sticky <= w_sticky | w_beat_err;
            if (w_last_beat)
                bresp_q <= (w_sticky || w_beat_err || (bus.wlast != (w_cnt == w_len))) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !w_beat_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_addr[MEM_AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.bid   = w_id;
    assign bus.bresp = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected R beats and B responses are queued as
// stimulus is driven and compared as the responder produces them.
module tb_axi_sram_slave;
    localparam int ID_W = 4;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if #(.ID_W(ID_W)) bus ();
    axi_sram_slave #(.MEM_AW(12), .ID_W(ID_W)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bresp_t;

    rbeat_t exp_r[$], got_r[$], stall_r[$];
    int     stall_idx[$];
    bresp_t exp_b[$], got_b[$];
    logic [31:0] model_mem [int];
    int checks = 0;
    int fails  = 0;

    function automatic rbeat_t mk_r(input logic [31:0] d, input logic [1:0] r, input logic [3:0] id,
                                    input logic l);
        rbeat_t b;
        b.data = d; b.resp = r; b.id = id; b.last = l;
        return b;
    endfunction

    function automatic bresp_t mk_b(input logic [1:0] r, input logic [3:0] id);
        bresp_t b;
        b.resp = r; b.id = id;
        return b;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        int idx = int'(addr >> 2);
        return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    endfunction

    function automatic void model_wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w = model_rd(addr);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model_mem[int'(addr >> 2)] = w;
    endfunction

    // Stimulus drivers; each wait is bounded and a missed handshake shows up as a short queue.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done = 1'b0;
        bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.arready;
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done = 1'b0;
        bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.awready;
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        bit done = 1'b0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.wready;
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
    endtask

    task automatic recv_r(input int n, input bit toggle, output int cycles);
        int got = 0;
        cycles = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            bus.rready = toggle ? (k % 2 == 0) : 1'b1;
            if (bus.rvalid && bus.rready) begin
                got_r.push_back(mk_r(bus.rdata, bus.rresp, bus.rid, bus.rlast));
                got++;
            end else if (bus.rvalid) begin
                stall_r.push_back(mk_r(bus.rdata, bus.rresp, bus.rid, bus.rlast));
                stall_idx.push_back(got);
            end
            cycles++;
            @(posedge clk); #1;
        end
        bus.rready = 1'b0;
    endtask

    task automatic recv_b();
        bit done = 1'b0;
        bus.bready = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (bus.bvalid) begin
                got_b.push_back(mk_b(bus.bresp, bus.bid));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        send_aw(id, a, 8'd0, 3'd2, 2'b01);
        send_w(d, s, 1'b1);
        exp_b.push_back(mk_b(2'b00, id));
        model_wr(a, d, s);
        recv_b();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid, bus.rlast, bus.rresp, bus.bresp} !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b, want 0", {bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid});
        end
        aresetn = 1'b1;
        checks++;
        if (bus.arready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release_early: arready got %b, want 0", bus.arready);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.arready, bus.awready} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL reset_release: arready/awready got %b, want 11", {bus.arready, bus.awready});
        end
    endtask

    task automatic test_single_write_read();
        int cyc = 0;
        int cycles;
        bit aw_now, w_now;
        rbeat_t e, g;
        bresp_t eb, gb;
        bus.awid = 4'd2; bus.awaddr = 32'h10; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while (!bus.bvalid && cyc < 20) begin
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_now) bus.awvalid = 1'b0;
            if (w_now)  bus.wvalid  = 1'b0;
        end
        checks++;
        if (cyc !== 2) begin
            fails++;
            $display("[TB] FAIL single_write_latency: bvalid after %0d cycles, want 2", cyc);
        end
        exp_b.push_back(mk_b(2'b00, 4'd2));
        model_wr(32'h10, 32'hDEADBEEF, 4'hF);
        recv_b();
        send_ar(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
        exp_r.push_back(mk_r(32'hDEADBEEF, 2'b00, 4'd1, 1'b1));
        recv_r(1, 1'b0, cycles);
        checks++;
        if (got_r.size() !== exp_r.size() || got_b.size() !== exp_b.size()) begin
            fails++;
            $display("[TB] FAIL single_count: got %0d/%0d, want %0d/%0d", got_r.size(), got_b.size(), exp_r.size(), exp_b.size());
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            eb = exp_b.pop_front(); gb = got_b.pop_front(); checks++;
            if (gb !== eb) begin
                fails++;
                $display("[TB] FAIL single_bresp: got resp=%b id=%h, want resp=%b id=%h", gb.resp, gb.id, eb.resp, eb.id);
            end
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL single_read: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        exp_r.delete(); got_r.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_strobe();
        int cycles;
        rbeat_t e, g;
        write_word(4'd3, 32'h14, 32'hFFFFFFFF, 4'hF);
        write_word(4'd3, 32'h14, 32'h12345678, 4'b0011);
        send_ar(4'd3, 32'h14, 8'd0, 3'd2, 2'b01);
        exp_r.push_back(mk_r(32'hFFFF5678, 2'b00, 4'd3, 1'b1));
        recv_r(1, 1'b0, cycles);
        checks++;
        if (got_b.size() !== exp_b.size() || got_b != exp_b) begin
            fails++;
            $display("[TB] FAIL strobe_bresp: got %0d responses, want %0d all OKAY", got_b.size(), exp_b.size());
        end
        checks++;
        if (got_r.size() !== exp_r.size()) begin
            fails++;
            $display("[TB] FAIL strobe_count: got %0d beats, want %0d", got_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL strobe_read: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        exp_r.delete(); got_r.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_incr_read();
        int cycles, idx;
        rbeat_t want[4];
        rbeat_t e, g;
        for (int i = 0; i < 4; i++) write_word(4'd1, 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h11), 4'hF);
        exp_b.delete(); got_b.delete();
        for (int i = 0; i < 4; i++) begin
            want[i] = mk_r(model_rd(32'(4 * i)), 2'b00, 4'd2, i == 3);
            exp_r.push_back(want[i]);
        end
        stall_r.delete(); stall_idx.delete();
        send_ar(4'd2, 32'h0, 8'd3, 3'd2, 2'b01);
        recv_r(4, 1'b1, cycles);
        checks++;
        if (got_r.size() !== exp_r.size()) begin
            fails++;
            $display("[TB] FAIL incr_count: got %0d beats, want %0d", got_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL incr_beat: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        checks++;
        if (stall_r.size() !== 3) begin
            fails++;
            $display("[TB] FAIL incr_stalls: got %0d stalled cycles, want 3", stall_r.size());
        end
        while (stall_r.size() > 0) begin
            g = stall_r.pop_front(); idx = stall_idx.pop_front(); checks++;
            if (idx > 3 || g !== want[idx]) begin
                fails++;
                $display("[TB] FAIL incr_stall_hold: beat %0d held %h/%b, want %h/%b", idx, g.data, g.last, want[idx & 3].data, want[idx & 3].last);
            end
        end
        exp_r.delete(); got_r.delete();
    endtask

    task automatic test_same_cycle();
        int cycles;
        rbeat_t e, g;
        write_word(4'd1, 32'h20, 32'h0, 4'hF);
        send_aw(4'd5, 32'h20, 8'd0, 3'd2, 2'b01);
        bus.wdata = 32'hA5; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.arid = 4'd3; bus.araddr = 32'h20; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        checks++;
        if ({bus.wready, bus.arready} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL same_cycle_ready: wready/arready got %b, want 11", {bus.wready, bus.arready});
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        exp_r.push_back(mk_r(32'h0, 2'b00, 4'd3, 1'b1));
        exp_b.push_back(mk_b(2'b00, 4'd5));
        model_wr(32'h20, 32'hA5, 4'hF);
        recv_r(1, 1'b0, cycles);
        recv_b();
        send_ar(4'd3, 32'h20, 8'd0, 3'd2, 2'b01);
        exp_r.push_back(mk_r(model_rd(32'h20), 2'b00, 4'd3, 1'b1));
        recv_r(1, 1'b0, cycles);
        checks++;
        if (got_b.size() !== exp_b.size() || got_b != exp_b) begin
            fails++;
            $display("[TB] FAIL same_cycle_bresp: got %0d responses, want %0d all OKAY", got_b.size(), exp_b.size());
        end
        checks++;
        if (got_r.size() !== exp_r.size()) begin
            fails++;
            $display("[TB] FAIL same_cycle_count: got %0d beats, want %0d", got_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL same_cycle_read: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        exp_r.delete(); got_r.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_errors();
        int cycles;
        rbeat_t e, g;
        bresp_t eb, gb;
        send_ar(4'd7, 32'h4000, 8'd0, 3'd2, 2'b01);
        exp_r.push_back(mk_r(32'h0, 2'b10, 4'd7, 1'b1));
        recv_r(1, 1'b0, cycles);
        send_ar(4'd7, 32'h10, 8'd1, 3'd2, 2'b10);
        exp_r.push_back(mk_r(32'h0, 2'b10, 4'd7, 1'b0));
        exp_r.push_back(mk_r(32'h0, 2'b10, 4'd7, 1'b1));
        recv_r(2, 1'b0, cycles);
        send_ar(4'd7, 32'h10, 8'd0, 3'd3, 2'b01);
        exp_r.push_back(mk_r(32'h0, 2'b10, 4'd7, 1'b1));
        recv_r(1, 1'b0, cycles);
        send_aw(4'd9, 32'h30, 8'd2, 3'd2, 2'b01);
        send_w(32'h11111111, 4'hF, 1'b0);
        send_w(32'h22222222, 4'hF, 1'b1);
        exp_b.push_back(mk_b(2'b10, 4'd9));
        recv_b();
        send_aw(4'd8, 32'h4000, 8'd0, 3'd2, 2'b01);
        send_w(32'h33333333, 4'hF, 1'b1);
        exp_b.push_back(mk_b(2'b10, 4'd8));
        recv_b();
        checks++;
        if (got_r.size() !== exp_r.size() || got_b.size() !== exp_b.size()) begin
            fails++;
            $display("[TB] FAIL err_count: got %0d/%0d, want %0d/%0d", got_r.size(), got_b.size(), exp_r.size(), exp_b.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL err_read: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            eb = exp_b.pop_front(); gb = got_b.pop_front(); checks++;
            if (gb !== eb) begin
                fails++;
                $display("[TB] FAIL err_bresp: got resp=%b id=%h, want resp=%b id=%h", gb.resp, gb.id, eb.resp, eb.id);
            end
        end
        exp_r.delete(); got_r.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_back_to_back();
        int cycles;
        rbeat_t e, g;
        send_aw(4'd4, 32'h40, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            send_w(32'hC0DE_0000 + 32'(i), 4'hF, i == 3);
            model_wr(32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
        end
        exp_b.push_back(mk_b(2'b00, 4'd4));
        recv_b();
        send_ar(4'd4, 32'h40, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) exp_r.push_back(mk_r(model_rd(32'h40 + 32'(4 * i)), 2'b00, 4'd4, i == 3));
        recv_r(4, 1'b0, cycles);
        checks++;
        if (cycles !== 4) begin
            fails++;
            $display("[TB] FAIL b2b_cycles: 4 beats took %0d cycles, want 4", cycles);
        end
        send_ar(4'd6, 32'h44, 8'd2, 3'd2, 2'b00);
        for (int i = 0; i < 3; i++) exp_r.push_back(mk_r(model_rd(32'h44), 2'b00, 4'd6, i == 2));
        recv_r(3, 1'b0, cycles);
        checks++;
        if (got_b.size() !== exp_b.size() || got_b != exp_b) begin
            fails++;
            $display("[TB] FAIL b2b_bresp: got %0d responses, want %0d all OKAY", got_b.size(), exp_b.size());
        end
        checks++;
        if (got_r.size() !== exp_r.size()) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d beats, want %0d", got_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL b2b_beat: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        exp_r.delete(); got_r.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_reset_mid_burst();
        int cycles;
        rbeat_t e, g;
        send_ar(4'd6, 32'h0, 8'd3, 3'd2, 2'b01);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        aresetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.rvalid, bus.arready} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL midburst_reset: rvalid/arready got %b, want 00", {bus.rvalid, bus.arready});
        end
        aresetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.arready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midburst_release: arready got %b, want 1", bus.arready);
        end
        send_ar(4'd6, 32'h0, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) exp_r.push_back(mk_r(model_rd(32'(4 * i)), 2'b00, 4'd6, i == 3));
        recv_r(4, 1'b0, cycles);
        checks++;
        if (got_r.size() !== exp_r.size()) begin
            fails++;
            $display("[TB] FAIL midburst_count: got %0d beats, want %0d", got_r.size(), exp_r.size());
        end
        while (exp_r.size() > 0 && got_r.size() > 0) begin
            e = exp_r.pop_front(); g = got_r.pop_front(); checks++;
            if (g !== e) begin
                fails++;
                $display("[TB] FAIL midburst_intact: got %h/%b/%h/%b, want %h/%b/%h/%b", g.data, g.resp, g.id, g.last, e.data, e.resp, e.id, e.last);
            end
        end
        exp_r.delete(); got_r.delete();
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_single_write_read();
        test_strobe();
        test_incr_read();
        test_same_cycle();
        test_errors();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
